alarm_clock_core: RTL

Timekeeping and edit engine for the alarm clock: consumes the one-cycle `clock_op_t` command pulses issued by the button/controller side and maintains running time, alarm setting, alarm enable and the edit cursor. Drives the field values and an update strobe toward the LCD display driver, which starts a `SEND_DATA` transfer on each strobe.

---
 rtl/alarm_clock_core.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/alarm_clock_core.sv
// Alarm clock timekeeping and edit engine.
// Keeps the live time, the alarm setting, the alarm enable and the edit cursor.
// Acts on one-cycle command pulses and drives registered display fields plus an
// update strobe toward the LCD driver.
//   clk, rst_n   : clock and asynchronous active-low reset
//   clock_op     : command pulses {display_time, set_time, set_alarm, toggle_alarm, left, up}
//   disp_hh/mm/ss: displayed fields
//   mode         : 0 DISPLAY, 1 SET_TIME, 2 SET_ALARM
//   cursor_hours : 1 = hours field selected, 0 = minutes field selected
//   alarm_en     : alarm armed
//   alarm_ring   : alarm sounding
//   disp_update  : one-cycle strobe after any visible change

package common_pkg;
  localparam int unsigned CLOCK_FREQ_DEFAULT = 2;

  typedef struct packed {
    logic display_time;
    logic set_time;
    logic set_alarm;
    logic toggle_alarm;
    logic left;
    logic up;
  } clock_op_t;
endpackage

module alarm_clock_core #(
  parameter int unsigned CLOCK_FREQ = common_pkg::CLOCK_FREQ_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] clock_op,
  output logic [4:0] disp_hh,
  output logic [5:0] disp_mm,
  output logic [5:0] disp_ss,
  output logic [1:0] mode,
  output logic       cursor_hours,
  output logic       alarm_en,
  output logic       alarm_ring,
  output logic       disp_update
);

  localparam int unsigned PRE_W = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;

  localparam logic [1:0] MODE_DISPLAY   = 2'd0;
  localparam logic [1:0] MODE_SET_TIME  = 2'd1;
  localparam logic [1:0] MODE_SET_ALARM = 2'd2;

  common_pkg::clock_op_t op;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [4:0] t_hh_q, t_hh_d, a_hh_q, a_hh_d, e_hh_q, e_hh_d;
  logic [5:0] t_mm_q, t_mm_d, a_mm_q, a_mm_d, e_mm_q, e_mm_d;
  logic [5:0] t_ss_q, t_ss_d;
  logic [1:0] mode_q, mode_d;
  logic       cursor_q, cursor_d, en_q, en_d, ring_q, ring_d, upd_q, upd_d;
  logic [4:0] dhh_q, dhh_d;
  logic [5:0] dmm_q, dmm_d, dss_q, dss_d;
  logic       tick, commit, cmd_any;

  assign op = common_pkg::clock_op_t'(clock_op);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      t_hh_q   <= 5'd0;
      t_mm_q   <= 6'd0;
      t_ss_q   <= 6'd0;
      a_hh_q   <= 5'd7;
      a_mm_q   <= 6'd0;
      e_hh_q   <= 5'd0;
      e_mm_q   <= 6'd0;
      mode_q   <= MODE_DISPLAY;
      cursor_q <= 1'b1;
      en_q     <= 1'b0;
      ring_q   <= 1'b0;
      upd_q    <= 1'b0;
      dhh_q    <= 5'd0;
      dmm_q    <= 6'd0;
      dss_q    <= 6'd0;
    end else begin
      pre_q    <= pre_d;
      t_hh_q   <= t_hh_d;
      t_mm_q   <= t_mm_d;
      t_ss_q   <= t_ss_d;
      a_hh_q   <= a_hh_d;
      a_mm_q   <= a_mm_d;
      e_hh_q   <= e_hh_d;
      e_mm_q   <= e_mm_d;
      mode_q   <= mode_d;
      cursor_q <= cursor_d;
      en_q     <= en_d;
      ring_q   <= ring_d;
      upd_q    <= upd_d;
      dhh_q    <= dhh_d;
      dmm_q    <= dmm_d;
      dss_q    <= dss_d;
    end
  end

  // Next-state: prescaler, time carry, prioritised command, ring, display
  always_comb begin
    pre_d    = pre_q + PRE_W'(1);
    t_hh_d   = t_hh_q;
    t_mm_d   = t_mm_q;
    t_ss_d   = t_ss_q;
    a_hh_d   = a_hh_q;
    a_mm_d   = a_mm_q;
    e_hh_d   = e_hh_q;
    e_mm_d   = e_mm_q;
    mode_d   = mode_q;
    cursor_d = cursor_q;
    en_d     = en_q;
    ring_d   = ring_q;
    commit   = 1'b0;
    cmd_any  = |clock_op;
    tick     = (pre_q == PRE_W'(CLOCK_FREQ - 1));

    if (tick) begin
      pre_d = '0;
      if (t_ss_q == 6'd59) begin
        t_ss_d = 6'd0;
        if (t_mm_q == 6'd59) begin
          t_mm_d = 6'd0;
          t_hh_d = (t_hh_q == 5'd23) ? 5'd0 : t_hh_q + 5'd1;
        end else begin
          t_mm_d = t_mm_q + 6'd1;
        end
      end else begin
        t_ss_d = t_ss_q + 6'd1;
      end
    end

    // Only the highest-priority asserted bit is acted on
    if (op.display_time) begin
      if (mode_q == MODE_SET_TIME) begin
        // Commit overrides any same-cycle tick
        t_hh_d = e_hh_q;
        t_mm_d = e_mm_q;
        t_ss_d = 6'd0;
        pre_d  = '0;
        commit = 1'b1;
        mode_d = MODE_DISPLAY;
      end else if (mode_q == MODE_SET_ALARM) begin
        a_hh_d = e_hh_q;
        a_mm_d = e_mm_q;
        mode_d = MODE_DISPLAY;
      end
    end else if (op.set_time) begin
      mode_d   = MODE_SET_TIME;
      e_hh_d   = t_hh_q;
      e_mm_d   = t_mm_q;
      cursor_d = 1'b1;
    end else if (op.set_alarm) begin
      mode_d   = MODE_SET_ALARM;
      e_hh_d   = a_hh_q;
      e_mm_d   = a_mm_q;
      cursor_d = 1'b1;
    end else if (op.toggle_alarm) begin
      en_d = ~en_q;
    end else if (op.left) begin
      if (mode_q != MODE_DISPLAY) cursor_d = ~cursor_q;
    end else if (op.up) begin
      if (mode_q != MODE_DISPLAY) begin
        if (cursor_q) e_hh_d = (e_hh_q == 5'd23) ? 5'd0 : e_hh_q + 5'd1;
        else          e_mm_d = (e_mm_q == 6'd59) ? 6'd0 : e_mm_q + 6'd1;
      end
    end

    // Clear first so a fresh match on the same tick keeps the ring set
    if (cmd_any || !en_d || (tick && t_ss_q == 6'd59)) ring_d = 1'b0;
    if (tick && !commit && en_d && t_ss_d == 6'd0 &&
        t_hh_d == a_hh_d && t_mm_d == a_mm_d) ring_d = 1'b1;

    if (mode_d == MODE_DISPLAY) begin
      dhh_d = t_hh_d;
      dmm_d = t_mm_d;
      dss_d = t_ss_d;
    end else begin
      dhh_d = e_hh_d;
      dmm_d = e_mm_d;
      dss_d = 6'd0;
    end

    upd_d = (dhh_d != dhh_q) || (dmm_d != dmm_q) || (dss_d != dss_q) ||
            (mode_d != mode_q) || (cursor_d != cursor_q) ||
            (en_d != en_q) || (ring_d != ring_q);
  end

  assign disp_hh      = dhh_q;
  assign disp_mm      = dmm_q;
  assign disp_ss      = dss_q;
  assign mode         = mode_q;
  assign cursor_hours = cursor_q;
  assign alarm_en     = en_q;
  assign alarm_ring   = ring_q;
  assign disp_update  = upd_q;

endmodule
